// File: rtl/lbc_stream_encoder_if.sv
// Streaming handshake bundle for the linear block code encoder: word input side,
// codeword output side and the current word position.
interface lbc_stream_encoder_if #(
    parameter int DATA_W    = 8,
    parameter int NUM_WORDS = 4,
    parameter int PARITY_W  = 6
);
    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam int CW_W  = DATA_W * NUM_WORDS + PARITY_W;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              abort;
    logic [CW_W-1:0]   out_cw;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  word_idx;

    modport master (
        output in_data, in_valid, abort, out_ready,
        input  in_ready, out_cw, out_valid, word_idx
    );

    modport slave (
        input  in_data, in_valid, abort, out_ready,
        output in_ready, out_cw, out_valid, word_idx
    );
endinterface

// File: rtl/lbc_stream_encoder.sv
// Linear block code encoder: collects NUM_WORDS input words, accumulates parity word by
// word through H_MATRIX, and presents data plus parity as one registered codeword.
module lbc_stream_encoder #(
    parameter int DATA_W    = 8,
    parameter int NUM_WORDS = 4,
    parameter int PARITY_W  = 6,
    parameter logic [DATA_W*NUM_WORDS*PARITY_W-1:0] H_MATRIX = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lbc_stream_encoder_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam int CW_W  = DATA_W * NUM_WORDS + PARITY_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    logic [IDX_W-1:0]                     idx_reg;
    logic [PARITY_W-1:0]                  acc_reg;
    logic [NUM_WORDS-2:0][DATA_W-1:0]     buf_reg;
    logic [CW_W-1:0]                      out_cw_reg;
    logic                                 out_valid_reg;

    logic [NUM_WORDS-1:0][PARITY_W-1:0]   contrib;
    logic [PARITY_W-1:0]                  contrib_sel;
    logic [CW_W-1:0]                      cw_next;
    logic                                 in_ready_int;
    logic                                 accept;
    logic                                 last_accept;

    // Parity contribution of the incoming word for every possible word position;
    // the current position selects one, so no codeword-wide XOR tree exists.
    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
            for (genvar gp = 0; gp < PARITY_W; gp++) begin : g_par
                logic [DATA_W-1:0] mask;
                for (genvar gb = 0; gb < DATA_W; gb++) begin : g_bit
                    assign mask[gb] = H_MATRIX[(gi*DATA_W+gb)*PARITY_W+gp];
                end
                assign contrib[gi][gp] = ^(bus.in_data & mask);
            end
        end
    endgenerate

    assign contrib_sel = contrib[idx_reg];

    generate
        for (genvar gi = 0; gi < NUM_WORDS - 1; gi++) begin : g_cw
            assign cw_next[PARITY_W+gi*DATA_W +: DATA_W] = buf_reg[gi];
        end
    endgenerate
    assign cw_next[CW_W-1 -: DATA_W]   = bus.in_data;
    assign cw_next[PARITY_W-1:0]       = acc_reg ^ contrib_sel;

    // Only the closing word must wait for the output register to drain.
    assign in_ready_int = !((idx_reg == LAST_IDX) && out_valid_reg && !bus.out_ready);
    assign accept       = bus.in_valid && in_ready_int && !bus.abort;
    assign last_accept  = accept && (idx_reg == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg       <= '0;
            acc_reg       <= '0;
            buf_reg       <= '0;
            out_cw_reg    <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (bus.abort) begin
                idx_reg <= '0;
                acc_reg <= '0;
            end else if (accept) begin
                if (last_accept) begin
                    idx_reg    <= '0;
                    acc_reg    <= '0;
                    out_cw_reg <= cw_next;
                end else begin
                    idx_reg <= idx_reg + IDX_W'(1);
                    acc_reg <= acc_reg ^ contrib_sel;
                    for (int i = 0; i < NUM_WORDS - 1; i++) begin
                        if (idx_reg == IDX_W'(i)) begin
                            buf_reg[i] <= bus.in_data;
                        end
                    end
                end
            end

            if (last_accept) begin
                out_valid_reg <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_cw    = out_cw_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.word_idx  = idx_reg;
endmodule

// File: tb/tb_lbc_stream_encoder.sv
// Bench for lbc_stream_encoder: directed vector table on the default configuration with an
// all-ones H_MATRIX, reset corner cases, and a randomized run of a small configuration.
module tb_lbc_stream_encoder;
    localparam int DW1 = 8;
    localparam int NW1 = 4;
    localparam int PW1 = 6;
    localparam int DW2 = 4;
    localparam int NW2 = 2;
    localparam int PW2 = 3;
    localparam logic [23:0] H2 = 24'h5B3E91;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lbc_stream_encoder_if #(.DATA_W(DW1), .NUM_WORDS(NW1), .PARITY_W(PW1)) bus1();
    lbc_stream_encoder_if #(.DATA_W(DW2), .NUM_WORDS(NW2), .PARITY_W(PW2)) bus2();

    lbc_stream_encoder #(
        .DATA_W(DW1), .NUM_WORDS(NW1), .PARITY_W(PW1),
        .H_MATRIX({(DW1*NW1*PW1){1'b1}})
    ) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    lbc_stream_encoder #(
        .DATA_W(DW2), .NUM_WORDS(NW2), .PARITY_W(PW2),
        .H_MATRIX(H2)
    ) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  d;
        logic        iv;
        logic        ab;
        logic        ordy;
        logic        exp_ir;
        logic        exp_ov;
        logic [1:0]  exp_idx;
        logic [37:0] exp_cw;
    } vec_t;

    vec_t tbl[$];

    task automatic addv(input logic [7:0] d, input logic iv, input logic ab, input logic ordy,
                        input logic ir, input logic ov, input logic [1:0] idx, input logic [37:0] cw);
        vec_t v;
        v.d = d; v.iv = iv; v.ab = ab; v.ordy = ordy;
        v.exp_ir = ir; v.exp_ov = ov; v.exp_idx = idx; v.exp_cw = cw;
        tbl.push_back(v);
    endtask

    // Reference for the small configuration: parity bit p is the XOR of every data bit j
    // whose H entry (j*PW2+p) is set, data bit j being bit j%DW2 of word j/DW2.
    function automatic logic [10:0] encode2(input logic [3:0] w0, input logic [3:0] w1);
        logic [23:0] h;
        logic [7:0]  d;
        logic [2:0]  p;
        h = H2;
        d = {w1, w0};
        p = '0;
        for (int j = 0; j < DW2 * NW2; j++) begin
            for (int pp = 0; pp < PW2; pp++) begin
                if (h[j*PW2+pp] && d[j]) p[pp] = ~p[pp];
            end
        end
        return {w1, w0, p};
    endfunction

    logic [3:0]  part[$];
    logic        m_ov;
    logic [10:0] m_cw;
    logic        exp_ir2, hs2, acc2, load2;
    int          accepted, consumed;

    initial begin
        bus1.in_data = '0; bus1.in_valid = 1'b0; bus1.abort = 1'b0; bus1.out_ready = 1'b0;
        bus2.in_data = '0; bus2.in_valid = 1'b0; bus2.abort = 1'b0; bus2.out_ready = 1'b0;

        // Reset state
        #12;
        chk("reset_out_valid", bus1.out_valid, 0);
        chk("reset_out_cw",    bus1.out_cw, 0);
        chk("reset_word_idx",  bus1.word_idx, 0);
        chk("reset_in_ready",  bus1.in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // d, in_valid, abort, out_ready | in_ready, out_valid, word_idx, out_cw
        addv(8'h01,1,0,1, 1,0,2'd0,38'h0);
        addv(8'h00,1,0,1, 1,0,2'd1,38'h0);
        addv(8'h00,1,0,1, 1,0,2'd2,38'h0);
        addv(8'h00,1,0,1, 1,0,2'd3,38'h0);
        addv(8'h03,1,0,1, 1,1,2'd0,38'h000000007F);
        addv(8'h00,1,0,1, 1,0,2'd1,38'h000000007F);
        addv(8'h00,1,0,1, 1,0,2'd2,38'h000000007F);
        addv(8'h00,1,0,1, 1,0,2'd3,38'h000000007F);
        addv(8'h11,1,0,0, 1,1,2'd0,38'h00000000C0);
        addv(8'h22,1,0,0, 1,1,2'd1,38'h00000000C0);
        addv(8'h44,1,0,0, 1,1,2'd2,38'h00000000C0);
        addv(8'h80,1,0,0, 0,1,2'd3,38'h00000000C0);
        addv(8'h80,1,0,0, 0,1,2'd3,38'h00000000C0);
        addv(8'h80,1,0,1, 1,1,2'd3,38'h00000000C0);
        addv(8'h00,0,0,0, 1,1,2'd0,38'h201108847F);
        addv(8'h00,0,0,1, 1,1,2'd0,38'h201108847F);
        addv(8'h05,1,0,1, 1,0,2'd0,38'h201108847F);
        addv(8'h06,1,0,1, 1,0,2'd1,38'h201108847F);
        addv(8'h07,1,1,1, 1,0,2'd2,38'h201108847F);
        addv(8'h01,1,0,1, 1,0,2'd0,38'h201108847F);
        addv(8'h00,1,0,1, 1,0,2'd1,38'h201108847F);
        addv(8'h00,1,0,1, 1,0,2'd2,38'h201108847F);
        addv(8'h00,1,0,1, 1,0,2'd3,38'h201108847F);
        addv(8'h00,0,1,0, 1,1,2'd0,38'h000000007F);
        addv(8'h00,0,0,0, 1,1,2'd0,38'h000000007F);
        addv(8'h00,0,0,1, 1,1,2'd0,38'h000000007F);
        addv(8'h00,0,0,0, 1,0,2'd0,38'h000000007F);

        foreach (tbl[r]) begin
            bus1.in_data   = tbl[r].d;
            bus1.in_valid  = tbl[r].iv;
            bus1.abort     = tbl[r].ab;
            bus1.out_ready = tbl[r].ordy;
            @(negedge clk);
            $display("row %0d: d=%h v=%b ab=%b ordy=%b -> ir=%b ov=%b idx=%0d cw=%h",
                     r, tbl[r].d, tbl[r].iv, tbl[r].ab, tbl[r].ordy,
                     bus1.in_ready, bus1.out_valid, bus1.word_idx, bus1.out_cw);
            chk($sformatf("row%0d_in_ready", r),  bus1.in_ready,  tbl[r].exp_ir);
            chk($sformatf("row%0d_out_valid", r), bus1.out_valid, tbl[r].exp_ov);
            chk($sformatf("row%0d_word_idx", r),  bus1.word_idx,  tbl[r].exp_idx);
            chk($sformatf("row%0d_out_cw", r),    bus1.out_cw,    tbl[r].exp_cw);
            @(posedge clk); #1;
        end

        // Asynchronous reset with a codeword pending and a partial one collected
        bus1.abort = 1'b0; bus1.out_ready = 1'b0; bus1.in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus1.in_data = 8'(1 << k);
            @(posedge clk); #1;
        end
        bus1.in_valid = 1'b0;
        #2;
        chk("prereset_out_valid", bus1.out_valid, 1);
        chk("prereset_word_idx",  bus1.word_idx, 2);
        rst_n = 1'b0;
        #1;
        $display("async reset: ov=%b idx=%0d cw=%h", bus1.out_valid, bus1.word_idx, bus1.out_cw);
        chk("async_rst_out_valid", bus1.out_valid, 0);
        chk("async_rst_out_cw",    bus1.out_cw, 0);
        chk("async_rst_word_idx",  bus1.word_idx, 0);
        chk("async_rst_in_ready",  bus1.in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        bus1.out_ready = 1'b1; bus1.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus1.in_data = (k == 0) ? 8'h01 : 8'h00;
            @(posedge clk); #1;
        end
        bus1.in_valid = 1'b0;
        $display("post-reset codeword: ov=%b cw=%h", bus1.out_valid, bus1.out_cw);
        chk("post_rst_out_valid", bus1.out_valid, 1);
        chk("post_rst_out_cw",    bus1.out_cw, 38'h000000007F);

        // Randomized run against the reference model
        m_ov = 1'b0; m_cw = '0; accepted = 0; consumed = 0;
        part.delete();
        for (int cyc = 0; cyc < 20000 && accepted < 1000; cyc++) begin
            bus2.in_data   = 4'($urandom_range(0, 15));
            bus2.in_valid  = ($urandom_range(0, 3) != 0);
            bus2.abort     = ($urandom_range(0, 49) == 0);
            bus2.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            exp_ir2 = !((part.size() == NW2 - 1) && m_ov && !bus2.out_ready);
            chk("rand_in_ready",  bus2.in_ready,  exp_ir2);
            chk("rand_out_valid", bus2.out_valid, m_ov);
            chk("rand_word_idx",  bus2.word_idx,  part.size());
            if (m_ov) chk("rand_out_cw", bus2.out_cw, m_cw);
            hs2   = m_ov && bus2.out_ready;
            acc2  = bus2.in_valid && exp_ir2 && !bus2.abort;
            load2 = 1'b0;
            if (hs2) begin
                consumed++;
                $display("codeword %0d consumed: cw=%h", consumed, bus2.out_cw);
            end
            if (bus2.abort) begin
                part.delete();
            end else if (acc2) begin
                part.push_back(bus2.in_data);
                accepted++;
                if (part.size() == NW2) begin
                    m_cw  = encode2(part[0], part[1]);
                    load2 = 1'b1;
                    part.delete();
                end
            end
            if (load2)    m_ov = 1'b1;
            else if (hs2) m_ov = 1'b0;
            @(posedge clk); #1;
        end
        chk("rand_accept_budget", (accepted >= 1000), 1);
        bus2.in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lbc_stream_encoder.md
LBC_STREAM_ENCODER -- requirements
Module: lbc_stream_encoder

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of one input word in bits, legal range 1..32.
REQ-002 SHALL have parameter NUM_WORDS, default 4: input words per codeword, legal range 2..16.
REQ-003 SHALL have parameter PARITY_W, default 6: parity bits per codeword, legal range 1..16.
REQ-004 SHALL have parameter H_MATRIX, width DATA_W*NUM_WORDS*PARITY_W, default all-zero: bit [j*PARITY_W+p] set means data bit j contributes to parity bit p.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 in_data  input  DATA_W  input data word.
REQ-009 in_valid  input  1  in_data is valid.
REQ-010 in_ready  output  1  encoder accepts in_data this cycle.
REQ-011 abort  input  1  synchronous; discards the partially collected codeword.
REQ-012 out_cw  output  DATA_W*NUM_WORDS+PARITY_W  codeword; word i at bits [PARITY_W+(i+1)*DATA_W-1 : PARITY_W+i*DATA_W], parity at [PARITY_W-1:0].
REQ-013 out_valid  output  1  out_cw holds a complete codeword.
REQ-014 out_ready  input  1  downstream consumes out_cw.
REQ-015 word_idx  output  clog2(NUM_WORDS)  index of the next word to be accepted.

Function
REQ-016 SHALL accept a word on the rising edge where in_valid && in_ready; word i is the i-th word accepted since the last codeword boundary or abort.
REQ-017 SHALL define data bit j as bit (j mod DATA_W) of word floor(j/DATA_W), and parity bit p as the XOR over all j with H_MATRIX[j*PARITY_W+p]=1.
REQ-018 SHALL accumulate parity incrementally: on each accept, XOR the masked contribution of that word into a PARITY_W accumulator and store the word in a collect buffer; no full-codeword XOR tree.
REQ-019 SHALL increment word_idx on each accept and wrap it from NUM_WORDS-1 to 0.
REQ-020 On accepting word NUM_WORDS-1 in cycle t, SHALL load the collect buffer, that word and the final parity into out_cw, and SHALL assert out_valid from cycle t+1; latency is one cycle.
REQ-021 SHALL clear the accumulator on the same edge that loads the output register, so a new codeword can start in cycle t+1.
REQ-022 SHALL hold out_cw and out_valid stable while out_valid && !out_ready.
REQ-023 SHALL deassert out_valid after an edge with out_valid && out_ready, unless a new codeword loads on that same edge, in which case out_valid stays 1 with the new out_cw.
REQ-024 in_ready SHALL be 1 except when word_idx==NUM_WORDS-1 && out_valid && !out_ready; words 0..NUM_WORDS-2 are accepted while the output is stalled.
REQ-025 in_ready SHALL be combinational from the registered state and out_ready only, never from in_valid.
REQ-026 abort SHALL clear word_idx and the accumulator on the next edge and take priority over a simultaneous accept, which is discarded; it SHALL NOT affect out_cw or out_valid.
REQ-027 SHALL sustain one accepted word per cycle indefinitely when out_ready is held at 1.

Reset
REQ-028 While rst_n=0, SHALL hold out_valid=0, out_cw=0, word_idx=0, the accumulator at 0 and the collect buffer at 0; in_ready=1.
REQ-029 Reset asserted mid-codeword SHALL discard the partial codeword; the first word accepted after release is word 0.

Verification
REQ-030 Default widths, H_MATRIX all ones, in_valid=1, out_ready=1, words 0x01,0x00,0x00,0x00 -> out_valid=1 one cycle after the 4th accept, out_cw=38'h000000007F.
REQ-031 Same configuration, words 0x03,0x00,0x00,0x00 sent back-to-back after REQ-030's codeword -> out_cw=38'h00000000C0, no idle cycle between the two out_valid pulses.
REQ-032 out_ready=0 with one codeword pending, then 4 more words offered -> 3 accepted, in_ready=0 at word_idx=3, first out_cw held; out_ready=1 -> word 3 accepted on the same edge, out_valid stays 1 with the second codeword.
REQ-033 Accept 2 words, pulse abort together with a 3rd valid word -> word_idx=0, that word discarded; next 4 words produce a codeword that depends only on those 4 words.
REQ-034 Drop rst_n asynchronously mid-codeword and while out_valid=1 -> out_valid=0, out_cw=0, word_idx=0 immediately, without a clock edge.
REQ-035 DATA_W=4, NUM_WORDS=2, PARITY_W=3, random H_MATRIX, 1000 random words with random out_ready -> every out_cw matches a reference model, with no codewords lost or duplicated.
